traffic_controller: RTL and testbench
=====================================

# traffic_controller

Parametrised multi-approach intersection controller. Sequences NUM_DIRS approaches through green, yellow and all-red phases using its own tick-driven down-counter, with no external master timer. Skips approaches that have no vehicle demand and rests in green when there is no competing demand. Sits between the 1 Hz tick generator and the lamp drivers. Supersedes the single-light decoder.

## Interface
- NUM_DIRS, 4: number of approaches; must be ≥2.
- TIMER_W, 7: phase-timer width.
- GREEN_TIME, 30: ticks per green phase; range 1..2^TIMER_W-1.
- YELLOW_TIME, 3: ticks per yellow phase; range 1..2^TIMER_W-1.
- ALL_RED_TIME, 1: ticks of all-red clearance; range 1..2^TIMER_W-1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle timing strobe (1 Hz nominal).
- enable  in  1  0 forces every approach red.
- sensor  in  NUM_DIRS  level demand per approach.
- green  out  NUM_DIRS  green lamp, one bit per approach.
- yellow  out  NUM_DIRS  yellow lamp, one bit per approach.
- red  out  NUM_DIRS  red lamp, one bit per approach.
- active_dir  out  $clog2(NUM_DIRS)  approach that currently owns (or last owned) green.
- phase_timer  out  TIMER_W  remaining ticks in the current phase.

## Operation
- States: OFF, GREEN, YELLOW, ALL_RED.
- Lamp mapping:
  - GREEN: green[active_dir]=1, every other approach red.
  - YELLOW: yellow[active_dir]=1, every other approach red.
  - ALL_RED and OFF: all red.
- Exactly one lamp per approach is lit at all times.
- Timer:
  - Loaded with the phase duration on entry to a phase.
  - Decrements by 1 on each tick.
  - A phase ends on the tick where phase_timer==1, so a phase lasts exactly its programmed number of ticks.
- End of GREEN:
  - Round-robin search over sensor, starting at active_dir+1 and excluding active_dir.
  - Hit: latch next_dir, go to YELLOW with YELLOW_TIME.
  - No hit: stay in GREEN, reload GREEN_TIME (rest-in-green).
- End of YELLOW: go to ALL_RED with ALL_RED_TIME.
- End of ALL_RED: active_dir←next_dir, go to GREEN with GREEN_TIME.
- The sensor bit of active_dir is ignored.
- Sensor is sampled only on the terminal green tick; demand is not latched elsewhere.
- enable=0 (synchronous, any state): go to OFF, phase_timer←0, active_dir held.
- enable 0→1: go to ALL_RED with ALL_RED_TIME, next_dir←active_dir, so the interrupted approach resumes.
- tick is ignored in OFF.

## Timing
- Reset (rst_n=0, asynchronous):
  - State ALL_RED, phase_timer=ALL_RED_TIME, active_dir=0, next_dir=0.
  - red all 1, green and yellow all 0.
- All outputs are registered. A transition caused by a tick sampled at edge k is visible after edge k.
- Timer and outputs do not change on non-tick cycles.
- enable and tick in the same cycle: enable=0 wins, no decrement.
- Reset released mid-phase: restarts from the reset state; no partial phase is retained.
- Round-robin wraps from NUM_DIRS-1 to 0.
- Green-to-green for a different approach takes YELLOW_TIME+ALL_RED_TIME ticks.

## Structure
- Package traffic_pkg holds:
  - the state enum typedef;
  - a lamp-vector struct typedef {green, yellow, red}.
- Sub-module traffic_rr_pick:
  - Combinational round-robin finder.
  - Inputs: request vector, start index, excluded index.
  - Outputs: found flag, index.
  - Parametrised by NUM_DIRS.
- Top level holds the FSM, timer, next_dir and output registers.

## Test plan
Configuration for all scenarios: NUM_DIRS=4, GREEN_TIME=5, YELLOW_TIME=3, ALL_RED_TIME=1, tick every 4 clocks.
- Reset, sensor=4'b0000 -> after 1 tick, green[0]=1. Dir 0 then rests in green, reloading every 5 ticks, with yellow never asserted.
- sensor=4'b1111 -> active_dir visits 0,1,2,3,0. Each approach gets 5 green, 3 yellow, 1 all-red ticks; the cycle is 36 ticks.
- active_dir=1, sensor=4'b0001 -> dir 1 yellows; next green is dir 0, with 2 and 3 skipped (wrap-around).
- enable dropped mid-green on dir 2 -> all red on the next edge, phase_timer=0. Re-enable gives 1 all-red tick, then green[2]=1 with phase_timer=5.
- rst_n pulsed low mid-yellow, asynchronously between edges -> outputs go to the reset state immediately. After release, green[0] follows 1 tick later.
- enable=0 coincident with the terminal green tick -> OFF; no yellow is ever shown.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and lamp decoding for the traffic controller
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_ALL_RED = 2'd3
  } state_t;

  typedef struct packed {
    logic green;
    logic yellow;
    logic red;
  } lamp_t;

  localparam lamp_t LAMP_RED    = '{green: 1'b0, yellow: 1'b0, red: 1'b1};
  localparam lamp_t LAMP_GREEN  = '{green: 1'b1, yellow: 1'b0, red: 1'b0};
  localparam lamp_t LAMP_YELLOW = '{green: 1'b0, yellow: 1'b1, red: 1'b0};

  // Only the approach that owns the phase shows green or yellow; all others show red.
  function automatic lamp_t lamp_for(input state_t st, input logic is_active);
    lamp_t l;
    l = LAMP_RED;
    if (is_active && st == ST_GREEN)  l = LAMP_GREEN;
    if (is_active && st == ST_YELLOW) l = LAMP_YELLOW;
    return l;
  endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// rtl/traffic_rr_pick.sv - combinational round-robin finder over a request vector
module traffic_rr_pick #(
  parameter int NUM_DIRS = 4,
  parameter int DIR_W    = $clog2(NUM_DIRS)
) (
  input  logic [NUM_DIRS-1:0] req,
  input  logic [DIR_W-1:0]    start,
  input  logic [DIR_W-1:0]    excl,
  output logic                found,
  output logic [DIR_W-1:0]    idx
);

  logic [DIR_W-1:0] cand;

  // Walk the ring from start, taking the first requester that is not the excluded index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_DIRS; i++) begin
      cand = DIR_W'((int'(start) + i) % NUM_DIRS);
      if (!found && req[cand] && cand != excl) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/traffic_controller.sv
// rtl/traffic_controller.sv - demand-driven multi-approach intersection sequencer
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int NUM_DIRS     = 4,
  parameter int TIMER_W      = 7,
  parameter int GREEN_TIME   = 30,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1,
  parameter int DIR_W        = $clog2(NUM_DIRS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                enable,
  input  logic [NUM_DIRS-1:0] sensor,
  output logic [NUM_DIRS-1:0] green,
  output logic [NUM_DIRS-1:0] yellow,
  output logic [NUM_DIRS-1:0] red,
  output logic [DIR_W-1:0]    active_dir,
  output logic [TIMER_W-1:0]  phase_timer
);

  localparam logic [TIMER_W-1:0] T_GREEN   = TIMER_W'(GREEN_TIME);
  localparam logic [TIMER_W-1:0] T_YELLOW  = TIMER_W'(YELLOW_TIME);
  localparam logic [TIMER_W-1:0] T_ALL_RED = TIMER_W'(ALL_RED_TIME);
  localparam logic [DIR_W-1:0]   LAST_DIR  = DIR_W'(NUM_DIRS - 1);

  state_t                      state_q, state_d;
  logic [TIMER_W-1:0]          timer_q, timer_d;
  logic [DIR_W-1:0]            dir_q, dir_d;
  logic [DIR_W-1:0]            next_q, next_d;
  lamp_t [NUM_DIRS-1:0]        lamps_q, lamps_d;

  logic [DIR_W-1:0]            search_start;
  logic                        pick_found;
  logic [DIR_W-1:0]            pick_idx;
  logic                        terminal;

  assign search_start = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_W'(1);
  assign terminal     = tick && (timer_q <= TIMER_W'(1));

  traffic_rr_pick #(
    .NUM_DIRS (NUM_DIRS),
    .DIR_W    (DIR_W)
  ) u_rr_pick (
    .req   (sensor),
    .start (search_start),
    .excl  (dir_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Phase sequencing, timer reload/decrement and the lamp pattern for the coming cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    next_d  = next_q;
    if (!enable) begin
      state_d = ST_OFF;
      timer_d = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          // Resume the interrupted approach after a clearance interval.
          state_d = ST_ALL_RED;
          timer_d = T_ALL_RED;
          next_d  = dir_q;
        end
        ST_GREEN: begin
          if (terminal) begin
            if (pick_found) begin
              state_d = ST_YELLOW;
              timer_d = T_YELLOW;
              next_d  = pick_idx;
            end else begin
              timer_d = T_GREEN;
            end
          end else if (tick) begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        ST_YELLOW: begin
          if (terminal) begin
            state_d = ST_ALL_RED;
            timer_d = T_ALL_RED;
          end else if (tick) begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        ST_ALL_RED: begin
          if (terminal) begin
            state_d = ST_GREEN;
            timer_d = T_GREEN;
            dir_d   = next_q;
          end else if (tick) begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        default: begin
          state_d = ST_ALL_RED;
          timer_d = T_ALL_RED;
        end
      endcase
    end
    for (int i = 0; i < NUM_DIRS; i++) begin
      lamps_d[i] = lamp_for(state_d, dir_d == DIR_W'(i));
    end
  end

  // State, timer, direction and lamp registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ALL_RED;
      timer_q <= T_ALL_RED;
      dir_q   <= '0;
      next_q  <= '0;
      lamps_q <= {NUM_DIRS{LAMP_RED}};
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      next_q  <= next_d;
      lamps_q <= lamps_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_DIRS; g++) begin : g_lamp_out
      assign green[g]  = lamps_q[g].green;
      assign yellow[g] = lamps_q[g].yellow;
      assign red[g]    = lamps_q[g].red;
    end
  endgenerate

  assign active_dir  = dir_q;
  assign phase_timer = timer_q;

endmodule

// File: tb/tb_traffic_controller.sv
// tb/tb_traffic_controller.sv - randomized self-checking bench for traffic_controller
module tb_traffic_controller;

  localparam int N   = 4;
  localparam int TW  = 7;
  localparam int G_T = 5;
  localparam int Y_T = 3;
  localparam int A_T = 1;

  logic          clk = 1'b0;
  logic          rst_n, tick, enable;
  logic [N-1:0]  sensor;
  logic [N-1:0]  green, yellow, red;
  logic [1:0]    active_dir;
  logic [TW-1:0] phase_timer;

  traffic_controller #(
    .NUM_DIRS (N), .TIMER_W (TW), .GREEN_TIME (G_T),
    .YELLOW_TIME (Y_T), .ALL_RED_TIME (A_T)
  ) dut (
    .clk (clk), .rst_n (rst_n), .tick (tick), .enable (enable), .sensor (sensor),
    .green (green), .yellow (yellow), .red (red),
    .active_dir (active_dir), .phase_timer (phase_timer)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: which phase the intersection shows, who owns it, ticks left.
  typedef enum int {P_OFF, P_GREEN, P_YELLOW, P_CLEAR} phase_e;
  phase_e m_phase;
  int     m_left, m_owner, m_queued;

  function automatic void model_reset();
    m_phase  = P_CLEAR;
    m_left   = A_T;
    m_owner  = 0;
    m_queued = 0;
  endfunction

  function automatic void model_step(input logic en, input logic tk, input logic [N-1:0] sen);
    int who;
    if (!en) begin
      m_phase = P_OFF;
      m_left  = 0;
      return;
    end
    if (m_phase == P_OFF) begin
      m_phase  = P_CLEAR;
      m_left   = A_T;
      m_queued = m_owner;
      return;
    end
    if (!tk) return;
    if (m_left > 1) begin
      m_left = m_left - 1;
      return;
    end
    case (m_phase)
      P_GREEN: begin
        who = -1;
        for (int k = 1; k < N; k++)
          if (who < 0 && sen[(m_owner + k) % N]) who = (m_owner + k) % N;
        if (who >= 0) begin
          m_phase  = P_YELLOW;
          m_left   = Y_T;
          m_queued = who;
        end else begin
          m_left = G_T;
        end
      end
      P_YELLOW: begin
        m_phase = P_CLEAR;
        m_left  = A_T;
      end
      default: begin
        m_phase = P_GREEN;
        m_left  = G_T;
        m_owner = m_queued;
      end
    endcase
  endfunction

  int           tick_count = 0;
  logic [N-1:0] prev_green = '0;
  logic [N-1:0] yellow_seen = '0;
  int           dir_log[$];
  int           g0_rise[$];

  task automatic compare_all();
    logic [N-1:0] eg, ey, er;
    for (int i = 0; i < N; i++) begin
      eg[i] = (m_phase == P_GREEN)  && (m_owner == i);
      ey[i] = (m_phase == P_YELLOW) && (m_owner == i);
      er[i] = !(eg[i] || ey[i]);
    end
    check_eq("green", green, eg);
    check_eq("yellow", yellow, ey);
    check_eq("red", red, er);
    check_eq("active_dir", active_dir, m_owner);
    check_eq("phase_timer", phase_timer, m_left);
    check_eq("one_lamp", ((green & yellow) | (green & red) | (yellow & red)) == '0 &&
             (green | yellow | red) == '1, 1);
    yellow_seen |= yellow;
    if (green != prev_green && green != '0) dir_log.push_back(int'(active_dir));
    if (green[0] && !prev_green[0]) g0_rise.push_back(tick_count);
    prev_green = green;
  endtask

  task automatic cycle(input logic tk);
    tick = tk;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(enable, tk, sensor);
    if (tk && rst_n) tick_count++;
    #1;
    compare_all();
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) begin
      cycle(1'b0); cycle(1'b0); cycle(1'b0); cycle(1'b1);
    end
  endtask

  // Asynchronous reset asserted between edges, checked before the next edge.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_red", red, 4'hF);
    check_eq("rst_green", green, 4'h0);
    check_eq("rst_timer", phase_timer, A_T);
    check_eq("rst_dir", active_dir, 0);
    compare_all();
    cycle(1'b0);
    cycle(1'b1);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; enable = 1'b1; sensor = '0;
    model_reset();
    cycle(1'b0); cycle(1'b0);
    #3 rst_n = 1'b1;

    // No demand: dir 0 rests in green, never yellow.
    ticks(1);
    check_eq("first_green", green, 4'b0001);
    yellow_seen = '0;
    ticks(16);
    check_eq("rest_no_yellow", yellow_seen, 0);
    check_eq("rest_green", green, 4'b0001);

    // Full demand: strict rotation, 36-tick cycle.
    dir_log.delete(); g0_rise.delete();
    sensor = 4'b1111;
    ticks(80);
    check_eq("rr_visits", dir_log.size() >= 5, 1);
    if (dir_log.size() >= 5)
      check_eq("rr_order", {dir_log[0][3:0], dir_log[1][3:0], dir_log[2][3:0],
                            dir_log[3][3:0], dir_log[4][3:0]}, 20'h12301);
    check_eq("g0_rises", g0_rise.size() >= 2, 1);
    if (g0_rise.size() >= 2)
      check_eq("cycle_ticks", g0_rise[g0_rise.size()-1] - g0_rise[g0_rise.size()-2], 36);

    // Wrap-around from dir 1 to dir 0 skipping 2 and 3.
    do_reset();
    sensor = 4'b0010;
    ticks(1); ticks(5); ticks(4);
    check_eq("dir1_green", green, 4'b0010);
    sensor = 4'b0001;
    ticks(5);
    check_eq("dir1_yellow", yellow, 4'b0010);
    ticks(3);
    check_eq("wrap_clear", red, 4'hF);
    ticks(1);
    check_eq("wrap_green", green, 4'b0001);
    check_eq("wrap_dir", active_dir, 0);

    // Enable dropped mid-green on dir 2, then resumed.
    do_reset();
    sensor = 4'b0100;
    ticks(1); ticks(5); ticks(4); ticks(2);
    check_eq("dir2_green", green, 4'b0100);
    enable = 1'b0;
    cycle(1'b0);
    check_eq("off_red", red, 4'hF);
    check_eq("off_timer", phase_timer, 0);
    check_eq("off_dir", active_dir, 2);
    sensor = 4'b0001;
    ticks(3);
    enable = 1'b1;
    cycle(1'b0);
    check_eq("resume_clear", red, 4'hF);
    check_eq("resume_timer", phase_timer, A_T);
    ticks(1);
    check_eq("resume_green", green, 4'b0100);
    check_eq("resume_gtimer", phase_timer, G_T);

    // Reset mid-yellow, then green[0] one tick after release.
    sensor = 4'b0010;
    ticks(6);
    check_eq("pre_rst_yellow", yellow, 4'b0100);
    do_reset();
    sensor = 4'b0000;
    ticks(1);
    check_eq("post_rst_green", green, 4'b0001);

    // enable=0 on the terminal green tick: OFF, no yellow ever.
    sensor = 4'b0010;
    ticks(4);
    cycle(1'b0); cycle(1'b0); cycle(1'b0);
    yellow_seen = '0;
    enable = 1'b0;
    cycle(1'b1);
    check_eq("kill_red", red, 4'hF);
    check_eq("kill_timer", phase_timer, 0);
    ticks(4);
    check_eq("kill_no_yellow", yellow_seen, 0);
    enable = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) sensor = N'($urandom);
      if ($urandom_range(99) == 0) enable = ~enable;
      else if (!enable && $urandom_range(7) == 0) enable = 1'b1;
      if (c == 1500) do_reset();
      cycle(($urandom_range(3) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
